// File: rtl/legv8_control_fsm.sv
// rtl/legv8_control_fsm.sv - multi-cycle LEGv8 control unit (fetch / execute / halt)
//
// Purpose: sequences a LEGv8 datapath through FETCH and EXECUTE and decodes the
// instruction register into datapath controls. Memory accesses stretch by
// MEM_WAIT cycles. Unknown opcodes park the machine in HALT until reset.
//
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   instruction               current IR contents
//   sr_status, alu_status     registered / live flags {V,C,N,Z}
//   DA, SA, SB                register file destination / A / B selects
//   W, C0, IL, SL             reg write, ALU carry-in, IR load, status load
//   PCsel, Bsel               PC_in source select, B operand = constant
//   FS, PS                    ALU function, PC mode (00 hold, 01 +4, 10 load, 11 add)
//   EN_ALU, EN_B, EN_PC       data bus drivers
//   EN_ADDR_ALU, EN_ADDR_PC   address bus drivers
//   constant                  immediate / branch offset
//   mem_oe, mem_we            memory drives data bus / memory write strobe
//   halted                    high while in HALT
module legv8_control_fsm #(
   parameter int unsigned MEM_WAIT = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] instruction,
   input  logic [3:0]  sr_status,
   input  logic [3:0]  alu_status,
   output logic [4:0]  DA,
   output logic [4:0]  SA,
   output logic [4:0]  SB,
   output logic        W,
   output logic        C0,
   output logic        IL,
   output logic        SL,
   output logic        PCsel,
   output logic        Bsel,
   output logic [4:0]  FS,
   output logic [1:0]  PS,
   output logic        EN_ALU,
   output logic        EN_B,
   output logic        EN_PC,
   output logic        EN_ADDR_ALU,
   output logic        EN_ADDR_PC,
   output logic [63:0] constant,
   output logic        mem_oe,
   output logic        mem_we,
   output logic        halted
);

   localparam logic [1:0] S_FETCH = 2'd0;
   localparam logic [1:0] S_EXEC  = 2'd1;
   localparam logic [1:0] S_HALT  = 2'd2;

   localparam logic [3:0] LAST_CNT = 4'(MEM_WAIT);

   localparam logic [4:0] FS_AND = 5'b00000;
   localparam logic [4:0] FS_ORR = 5'b00100;
   localparam logic [4:0] FS_ADD = 5'b01000;
   localparam logic [4:0] FS_SUB = 5'b01001;
   localparam logic [4:0] FS_EOR = 5'b01100;

   logic [1:0] state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   logic [10:0] op11;
   logic [9:0]  op10;
   logic [4:0]  rd, rn, rm;
   logic        last;
   logic        r_op, i_op, mem_op, is_load, is_b, is_cb, is_bcond;
   logic        alu_c0, alu_sl, cb_taken, bc_valid, bc_taken;
   logic [4:0]  alu_fs;
   logic [63:0] imm12, imm9, off_b, off_19;
   logic        unused_flags;

   assign op11 = instruction[31:21];
   assign op10 = instruction[31:22];
   assign rd   = instruction[4:0];
   assign rn   = instruction[9:5];
   assign rm   = instruction[20:16];
   assign last = (cnt_q == LAST_CNT);

   assign imm12  = {52'd0, instruction[21:10]};
   assign imm9   = {{55{instruction[20]}}, instruction[20:12]};
   // PC already advanced by 4 during FETCH, so branch offsets are pre-corrected.
   assign off_b  = {{36{instruction[25]}}, instruction[25:0], 2'b00} - 64'd4;
   assign off_19 = {{43{instruction[23]}}, instruction[23:5], 2'b00} - 64'd4;

   // Carry flag and the upper live flags play no part in any decision here.
   assign unused_flags = &{1'b0, sr_status[2], alu_status[3:1]};

   always_comb begin
      r_op = 1'b1;  i_op = 1'b1;
      alu_fs = FS_ADD;  alu_c0 = 1'b0;  alu_sl = 1'b0;
      case (op11)
         11'b10001011000: alu_fs = FS_ADD;                                      // ADD
         11'b11001011000: begin alu_fs = FS_SUB; alu_c0 = 1'b1; end             // SUB
         11'b10001010000: alu_fs = FS_AND;                                      // AND
         11'b10101010000: alu_fs = FS_ORR;                                      // ORR
         11'b11001010000: alu_fs = FS_EOR;                                      // EOR
         11'b10101011000: begin alu_fs = FS_ADD; alu_sl = 1'b1; end             // ADDS
         11'b11101011000: begin alu_fs = FS_SUB; alu_c0 = 1'b1; alu_sl = 1'b1; end // SUBS
         default: r_op = 1'b0;
      endcase
      if (!r_op) begin
         case (op10)
            10'b1001000100: alu_fs = FS_ADD;                                    // ADDI
            10'b1101000100: begin alu_fs = FS_SUB; alu_c0 = 1'b1; end           // SUBI
            10'b1001001000: alu_fs = FS_AND;                                    // ANDI
            10'b1011001000: alu_fs = FS_ORR;                                    // ORRI
            10'b1101001000: alu_fs = FS_EOR;                                    // EORI
            10'b1111000100: begin alu_fs = FS_SUB; alu_c0 = 1'b1; alu_sl = 1'b1; end // SUBIS
            default: i_op = 1'b0;
         endcase
      end else begin
         i_op = 1'b0;
      end
   end

   assign is_load  = (op11 == 11'b11111000010);
   assign mem_op   = is_load || (op11 == 11'b11111000000);
   assign is_b     = (instruction[31:26] == 6'b000101);
   assign is_cb    = (instruction[31:25] == 7'b1011010);
   assign is_bcond = (instruction[31:24] == 8'b01010100);
   // CBZ (bit 24 = 0) branches on Z=1, CBNZ on Z=0.
   assign cb_taken = alu_status[0] ^ instruction[24];

   always_comb begin
      bc_valid = 1'b1;
      case (instruction[3:0])
         4'h0:    bc_taken = sr_status[0];
         4'h1:    bc_taken = !sr_status[0];
         4'hA:    bc_taken = (sr_status[1] == sr_status[3]);
         4'hB:    bc_taken = (sr_status[1] != sr_status[3]);
         default: begin bc_taken = 1'b0; bc_valid = 1'b0; end
      endcase
   end

   always_comb begin
      state_d = state_q;  cnt_d = cnt_q;
      DA = '0;  SA = '0;  SB = '0;  FS = '0;  PS = '0;  constant = '0;
      W = 1'b0;  C0 = 1'b0;  IL = 1'b0;  SL = 1'b0;  PCsel = 1'b0;  Bsel = 1'b0;
      EN_ALU = 1'b0;  EN_B = 1'b0;  EN_PC = 1'b0;
      EN_ADDR_ALU = 1'b0;  EN_ADDR_PC = 1'b0;
      mem_oe = 1'b0;  mem_we = 1'b0;  halted = 1'b0;
      // Holding everything at zero while reset is high also suppresses any
      // W / mem_we pulse from an operation that the reset aborts.
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               EN_ADDR_PC = 1'b1;
               mem_oe     = 1'b1;
               if (last) begin
                  IL = 1'b1;  PS = 2'b01;
                  state_d = S_EXEC;  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            S_EXEC: begin
               state_d = S_FETCH;  cnt_d = '0;
               if (r_op || i_op) begin
                  SA = rn;  DA = rd;  FS = alu_fs;  C0 = alu_c0;  SL = alu_sl;
                  EN_ALU = 1'b1;  W = (rd != 5'd31);
                  if (r_op) SB = rm;
                  else begin Bsel = 1'b1; constant = imm12; end
               end else if (mem_op) begin
                  SA = rn;  Bsel = 1'b1;  constant = imm9;  FS = FS_ADD;
                  EN_ADDR_ALU = 1'b1;
                  if (is_load) begin
                     mem_oe = 1'b1;  DA = rd;  W = last && (rd != 5'd31);
                  end else begin
                     SB = rd;  EN_B = 1'b1;  mem_we = last;
                  end
                  if (!last) begin
                     state_d = S_EXEC;  cnt_d = cnt_q + 4'd1;
                  end
               end else if (is_b) begin
                  PCsel = 1'b1;  PS = 2'b11;  constant = off_b;
               end else if (is_cb) begin
                  SA = rd;  Bsel = 1'b1;  FS = FS_ADD;
                  if (cb_taken) begin PS = 2'b11; constant = off_19; end
               end else if (is_bcond && bc_valid) begin
                  if (bc_taken) begin PS = 2'b11; constant = off_19; end
               end else begin
                  state_d = S_HALT;
               end
            end
            default: begin
               halted  = 1'b1;
               state_d = S_HALT;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_legv8_control_fsm.sv
// tb/tb_legv8_control_fsm.sv - scoreboard bench for legv8_control_fsm
module tb_legv8_control_fsm;

   typedef struct packed {
      logic [4:0]  DA, SA, SB;
      logic        W, C0, IL, SL, PCsel, Bsel;
      logic [4:0]  FS;
      logic [1:0]  PS;
      logic        EN_ALU, EN_B, EN_PC, EN_ADDR_ALU, EN_ADDR_PC;
      logic [63:0] constant;
      logic        mem_oe, mem_we, halted;
   } ctl_t;

   typedef struct {
      string tag;
      int    inst;
      ctl_t  exp;
   } sb_t;

   localparam logic [4:0] FS_ADD = 5'b01000;
   localparam logic [4:0] FS_SUB = 5'b01001;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] instruction = '0;
   logic [3:0]  sr_status = '0;
   logic [3:0]  alu_status = '0;
   ctl_t        obs [3];
   sb_t         sb_q [$];
   sb_t         mon_e;
   int          n_checks = 0;
   int          n_pass = 0;

   always #5 clock = ~clock;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      ctl_t o;
      legv8_control_fsm #(.MEM_WAIT((g == 0) ? 0 : (g == 1) ? 2 : 3)) u_dut (
         .clock(clock), .reset(reset), .instruction(instruction),
         .sr_status(sr_status), .alu_status(alu_status),
         .DA(o.DA), .SA(o.SA), .SB(o.SB),
         .W(o.W), .C0(o.C0), .IL(o.IL), .SL(o.SL), .PCsel(o.PCsel), .Bsel(o.Bsel),
         .FS(o.FS), .PS(o.PS),
         .EN_ALU(o.EN_ALU), .EN_B(o.EN_B), .EN_PC(o.EN_PC),
         .EN_ADDR_ALU(o.EN_ADDR_ALU), .EN_ADDR_PC(o.EN_ADDR_PC),
         .constant(o.constant), .mem_oe(o.mem_oe), .mem_we(o.mem_we), .halted(o.halted)
      );
      assign obs[g] = o;
   end

   task automatic check(input string tag, input ctl_t got, input ctl_t exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   always @(negedge clock) begin
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         check(mon_e.tag, obs[mon_e.inst], mon_e.exp);
      end
   end

   function automatic ctl_t e_fetch(input logic lst);
      ctl_t e = '0;
      e.EN_ADDR_PC = 1'b1;  e.mem_oe = 1'b1;
      e.IL = lst;  e.PS = lst ? 2'b01 : 2'b00;
      return e;
   endfunction

   function automatic ctl_t e_alu(input logic [4:0] sa, sb, da, fs, input logic c0, sl,
                                  bsel, w, input logic [63:0] k);
      ctl_t e = '0;
      e.SA = sa;  e.SB = sb;  e.DA = da;  e.FS = fs;  e.C0 = c0;  e.SL = sl;
      e.Bsel = bsel;  e.W = w;  e.constant = k;  e.EN_ALU = 1'b1;
      return e;
   endfunction

   function automatic ctl_t e_mem(input logic store, input logic [4:0] rn, rt,
                                  input logic [63:0] k, input logic lst);
      ctl_t e = '0;
      e.SA = rn;  e.Bsel = 1'b1;  e.constant = k;  e.FS = FS_ADD;  e.EN_ADDR_ALU = 1'b1;
      if (store) begin e.SB = rt; e.EN_B = 1'b1; e.mem_we = lst; end
      else       begin e.DA = rt; e.mem_oe = 1'b1; e.W = lst; end
      return e;
   endfunction

   function automatic ctl_t e_br(input logic [4:0] sa, input logic bsel, input logic [4:0] fs,
                                 input logic [1:0] ps, input logic pcsel, input logic [63:0] k);
      ctl_t e = '0;
      e.SA = sa;  e.Bsel = bsel;  e.FS = fs;  e.PS = ps;  e.PCsel = pcsel;  e.constant = k;
      return e;
   endfunction

   function automatic ctl_t e_halt();
      ctl_t e = '0;
      e.halted = 1'b1;
      return e;
   endfunction

   // One clock: drive inputs just after the edge and queue what the DUT must show.
   task automatic cyc(input logic rst, input logic [31:0] ins, input logic [3:0] sr, alu,
                      input int inst, input string tag, input ctl_t exp);
      sb_t e;
      @(posedge clock);
      #1;
      reset = rst;  instruction = ins;  sr_status = sr;  alu_status = alu;
      e.tag = tag;  e.inst = inst;  e.exp = exp;
      sb_q.push_back(e);
   endtask

   localparam logic [31:0] I_ADD   = 32'h8B020023; // ADD  X3, X1, X2
   localparam logic [31:0] I_SUBS  = 32'hEB02003F; // SUBS XZR, X1, X2
   localparam logic [31:0] I_ADDI  = 32'h91001422; // ADDI X2, X1, #5
   localparam logic [31:0] I_CBZ   = 32'hB4000064; // CBZ  X4, +3
   localparam logic [31:0] I_CBNZ  = 32'hB5000064; // CBNZ X4, +3
   localparam logic [31:0] I_B     = 32'h17FFFFFF; // B    -1
   localparam logic [31:0] I_BLT   = 32'h5400004B; // B.LT +2
   localparam logic [31:0] I_BBAD  = 32'h54000045; // B.cond with cond 5
   localparam logic [31:0] I_LDUR  = 32'hF85F80C5; // LDUR X5, [X6, #-8]
   localparam logic [31:0] I_STUR  = 32'hF80100C7; // STUR X7, [X6, #16]
   localparam logic [63:0] K_M8    = 64'hFFFFFFFFFFFFFFF8;

   initial begin
      cyc(1, I_ADD, 4'h0, 4'h0, 0, "reset_zero", '0);
      cyc(0, I_ADD, 4'h0, 4'h0, 0, "add_fetch", e_fetch(1));
      cyc(0, I_ADD, 4'h0, 4'h0, 0, "add_exec", e_alu(1, 2, 3, FS_ADD, 0, 0, 0, 1, 0));
      cyc(0, I_ADD, 4'h0, 4'h0, 0, "add_refetch", e_fetch(1));

      cyc(1, I_SUBS, 4'h0, 4'h0, 0, "subs_reset", '0);
      cyc(0, I_SUBS, 4'h0, 4'h0, 0, "subs_fetch", e_fetch(1));
      cyc(0, I_SUBS, 4'h0, 4'h0, 0, "subs_xzr", e_alu(1, 2, 31, FS_SUB, 1, 1, 0, 0, 0));
      cyc(0, I_ADDI, 4'h0, 4'h0, 0, "addi_fetch", e_fetch(1));
      cyc(0, I_ADDI, 4'h0, 4'h0, 0, "addi_exec", e_alu(1, 0, 2, FS_ADD, 0, 0, 1, 1, 64'd5));

      cyc(0, I_CBZ, 4'h0, 4'b0000, 0, "cbz_fetch", e_fetch(1));
      cyc(0, I_CBZ, 4'h0, 4'b0001, 0, "cbz_taken", e_br(4, 1, FS_ADD, 2'b11, 0, 64'd8));
      cyc(0, I_CBZ, 4'h0, 4'b0000, 0, "cbz_fetch2", e_fetch(1));
      cyc(0, I_CBZ, 4'h0, 4'b0000, 0, "cbz_not_taken", e_br(4, 1, FS_ADD, 2'b00, 0, 64'd0));
      cyc(0, I_CBNZ, 4'h0, 4'b0000, 0, "cbnz_fetch", e_fetch(1));
      cyc(0, I_CBNZ, 4'h0, 4'b0000, 0, "cbnz_taken", e_br(4, 1, FS_ADD, 2'b11, 0, 64'd8));

      cyc(0, I_B, 4'h0, 4'h0, 0, "b_fetch", e_fetch(1));
      cyc(0, I_B, 4'h0, 4'h0, 0, "b_exec", e_br(0, 0, 5'd0, 2'b11, 1, K_M8));
      cyc(0, I_BLT, 4'b0010, 4'h0, 0, "blt_fetch", e_fetch(1));
      cyc(0, I_BLT, 4'b0010, 4'h0, 0, "blt_taken", e_br(0, 0, 5'd0, 2'b11, 0, 64'd4));
      cyc(0, I_BLT, 4'b1010, 4'h0, 0, "blt_fetch2", e_fetch(1));
      cyc(0, I_BLT, 4'b1010, 4'h0, 0, "blt_not_taken", e_br(0, 0, 5'd0, 2'b00, 0, 64'd0));
      cyc(0, I_BBAD, 4'h0, 4'h0, 0, "bbad_fetch", e_fetch(1));
      cyc(0, I_BBAD, 4'h0, 4'h0, 0, "bbad_exec", '0);
      cyc(0, I_BBAD, 4'h0, 4'h0, 0, "bbad_halt", e_halt());

      cyc(1, 32'h0, 4'h0, 4'h0, 0, "zero_reset", '0);
      cyc(0, 32'h0, 4'h0, 4'h0, 0, "zero_fetch", e_fetch(1));
      cyc(0, 32'h0, 4'h0, 4'h0, 0, "zero_exec", '0);
      for (int i = 0; i < 10; i++)
         cyc(0, 32'h0, 4'hF, 4'hF, 0, $sformatf("halt_%0d", i), e_halt());
      cyc(1, 32'h0, 4'h0, 4'h0, 0, "halt_reset", '0);
      cyc(0, 32'h0, 4'h0, 4'h0, 0, "halt_refetch", e_fetch(1));

      cyc(1, I_LDUR, 4'h0, 4'h0, 1, "ldur_reset", '0);
      cyc(0, I_LDUR, 4'h0, 4'h0, 1, "ldur_fetch1", e_fetch(0));
      cyc(0, I_LDUR, 4'h0, 4'h0, 1, "ldur_fetch2", e_fetch(0));
      cyc(0, I_LDUR, 4'h0, 4'h0, 1, "ldur_fetch3", e_fetch(1));
      cyc(0, I_LDUR, 4'h0, 4'h0, 1, "ldur_exec1", e_mem(0, 6, 5, K_M8, 0));
      cyc(0, I_LDUR, 4'h0, 4'h0, 1, "ldur_exec2", e_mem(0, 6, 5, K_M8, 0));
      cyc(0, I_LDUR, 4'h0, 4'h0, 1, "ldur_exec3", e_mem(0, 6, 5, K_M8, 1));
      cyc(0, I_LDUR, 4'h0, 4'h0, 1, "ldur_refetch", e_fetch(0));

      cyc(1, I_STUR, 4'h0, 4'h0, 2, "stur_reset", '0);
      for (int i = 0; i < 4; i++)
         cyc(0, I_STUR, 4'h0, 4'h0, 2, $sformatf("stur_fetch%0d", i), e_fetch(i == 3));
      for (int i = 0; i < 3; i++)
         cyc(0, I_STUR, 4'h0, 4'h0, 2, $sformatf("stur_exec%0d", i), e_mem(1, 6, 7, 64'd16, 0));
      cyc(1, I_STUR, 4'h0, 4'h0, 2, "stur_abort", '0);
      cyc(0, I_STUR, 4'h0, 4'h0, 2, "stur_after_abort", e_fetch(0));

      @(posedge clock);
      @(negedge clock);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/legv8_control_fsm.md
LEGV8_CONTROL_FSM -- requirements
Module: legv8_control_fsm

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 0: extra wait cycles per memory access, range 0..15.
REQ-002 SHALL have port clock, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port instruction, input, 32 bits: current IR contents.
REQ-005 SHALL have port sr_status, input, 4 bits: registered flags {V,C,N,Z}.
REQ-006 SHALL have port alu_status, input, 4 bits: live ALU flags {V,C,N,Z}.
REQ-007 SHALL have ports DA, SA, SB, outputs, 5 bits each: register file select fields.
REQ-008 SHALL have ports W, C0, IL, SL, PCsel, Bsel, outputs, 1 bit each: datapath controls.
REQ-009 SHALL have ports FS (5 bits) and PS (2 bits), outputs: ALU function and PC mode.
REQ-010 SHALL have ports EN_ALU, EN_B, EN_PC, EN_ADDR_ALU, EN_ADDR_PC, outputs, 1 bit each: tristate enables.
REQ-011 SHALL have port constant, output, 64 bits: immediate or branch offset.
REQ-012 SHALL have ports mem_oe and mem_we, outputs, 1 bit each: memory drives data bus / memory write strobe.
REQ-013 SHALL have port halted, output, 1 bit: high while in HALT.

Function
REQ-014 SHALL implement states FETCH, EXECUTE and HALT, plus a 4-bit wait counter.
REQ-015 FETCH SHALL assert EN_ADDR_PC and mem_oe for MEM_WAIT+1 cycles; IL=1 and PS=01 only on the final cycle; then go to EXECUTE.
REQ-016 EXECUTE SHALL last 1 cycle for non-memory instructions and MEM_WAIT+1 cycles for LDUR/STUR, then go to FETCH.
REQ-017 SHALL encode PS as 00 hold, 01 PC+4, 10 load PC_in, 11 PC+PC_in.
REQ-018 SHALL encode FS as FS[4:2] 000 AND, 001 OR, 010 ADD, 011 XOR, with FS[1] invert A and FS[0] invert B.
REQ-019 SHALL encode subtract as FS=01001 with C0=1; every other operation SHALL use C0=0.
REQ-020 R-type ADD/SUB/AND/ORR/EOR/ADDS/SUBS SHALL drive SA=Rn[9:5], SB=Rm[20:16], Bsel=0, EN_ALU=1, DA=Rd[4:0], W=1.
REQ-021 ADDS/SUBS SHALL additionally assert SL=1.
REQ-022 I-type ADDI/SUBI/ANDI/ORRI/EORI/SUBIS SHALL use Bsel=1 and constant = zero-extended imm12[21:10]; SUBIS SHALL assert SL=1.
REQ-023 LDUR SHALL drive SA=Rn, Bsel=1, constant = sign-extended imm9[20:12], FS=ADD, EN_ADDR_ALU=1, mem_oe=1, DA=Rt, with W=1 on the final cycle only.
REQ-024 STUR SHALL drive the LDUR address path, plus SB=Rt, EN_B=1, mem_oe=0, with mem_we=1 on the final cycle only.
REQ-025 B SHALL drive PCsel=1, PS=11, constant = sign-extend(imm26<<2) - 4.
REQ-026 CBZ/CBNZ SHALL drive SA=Rt, Bsel=1, constant=0, FS=ADD.
REQ-027 CBZ/CBNZ SHALL branch with offset sign-extend(imm19[23:5]<<2) - 4 and PS=11 when alu_status[0] is 1 (CBZ) or 0 (CBNZ); otherwise PS=00.
REQ-028 B.cond SHALL test sr_status for EQ (0), NE (1), LT (B), GE (A), using N!=V for LT.
REQ-029 B.cond SHALL use the B offset rule with imm19 when taken; any other cond SHALL take the illegal-opcode path.
REQ-030 When Rd or Rt equals 31, W SHALL be forced to 0 (XZR); flags are still set where REQ-021/REQ-022 require.
REQ-031 An unrecognised opcode SHALL enter HALT; HALT SHALL assert halted=1 and hold all enables, W, SL, IL, mem_we and PS at 0 until reset.
REQ-032 At most one of EN_ALU, EN_B, EN_PC and mem_oe SHALL be 1 in any cycle.
REQ-033 At most one of EN_ADDR_ALU and EN_ADDR_PC SHALL be 1 in any cycle.
REQ-034 Outputs SHALL be decoded combinationally from the registered state, the wait counter and instruction.
REQ-035 All outputs not named for the current state and instruction SHALL be 0.

Reset
REQ-036 While reset=1, all outputs SHALL be 0.
REQ-037 On the first edge after reset is sampled high: state SHALL be FETCH, counter 0, halted 0.
REQ-038 A reset during any state or mid-wait SHALL abort the operation with no W or mem_we pulse in the reset cycle.

Verification
REQ-039 MEM_WAIT=0, instruction=ADD X3,X1,X2 -> FETCH cycle with IL=1 and PS=01, then EXECUTE with SA=1, SB=2, DA=3, FS=01000, W=1, EN_ALU=1.
REQ-040 MEM_WAIT=2, LDUR X5,[X6,#-8] -> FETCH lasts 3 cycles with IL only in cycle 3; EXECUTE lasts 3 cycles with constant=64'hFFFFFFFFFFFFFFF8 and W=1 only in cycle 3.
REQ-041 CBZ X4,+3 with alu_status=4'b0001 -> PS=11, constant=8; with alu_status=4'b0000 -> PS=00.
REQ-042 SUBS XZR,X1,X2 -> W=0, SL=1, FS=01001, C0=1.
REQ-043 instruction=32'h00000000 -> HALT with halted=1 and no enables asserted for 10 cycles; reset -> FETCH.
REQ-044 Reset asserted in the middle of a STUR wait (MEM_WAIT=3) -> mem_we never pulses; next state FETCH.
